// File: rtl/channel_fifo_pkg.sv
// channel_fifo_pkg: 4-phase handshake FSM encodings, shared with router rx/tx.
`ifndef CHANNEL_DEFS
`define CHANNEL_DEFS
`define IN_IDLE  1'b0
`define IN_ACK   1'b1
`define OUT_IDLE 2'd0
`define OUT_REQ  2'd1
`define OUT_WAIT 2'd2
`endif
package channel_fifo_pkg;
  typedef enum logic {IN_IDLE = `IN_IDLE, IN_ACK = `IN_ACK} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE = `OUT_IDLE, OUT_REQ = `OUT_REQ, OUT_WAIT = `OUT_WAIT} out_state_e;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x SIZE register array, synchronous write, asynchronous read.
module fifo_mem #(
  parameter int SIZE      = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [SIZE-1:0]      wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [SIZE-1:0]      rd_data
);
  logic [SIZE-1:0] mem_q [2**ADDR_BITS];
  always_ff @(posedge clk) if (we) mem_q[wr_addr] <= wr_data;
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/channel_fifo.sv
// channel_fifo: elastic link buffer between two 4-phase req/ack channels.
// Define CHANNEL_FIFO_DEBUG_EN for push/pop trace and an in_data stability check.
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int ADDR_BITS = 2,
  parameter int ID        = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req,
  output logic                 in_ack,
  input  logic [SIZE-1:0]      in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [SIZE-1:0]      out_data,
  output logic [ADDR_BITS:0]   count
);
  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(2**ADDR_BITS);
  in_state_e            in_st_q, in_st_d;
  out_state_e           out_st_q, out_st_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [SIZE-1:0]      out_data_q, out_data_d, rd_data;
  logic                 push, pop;

  fifo_mem #(.SIZE(SIZE), .ADDR_BITS(ADDR_BITS)) u_mem (
    .clk(clk), .we(push), .wr_addr(wr_ptr_q), .wr_data(in_data),
    .rd_addr(rd_ptr_q), .rd_data(rd_data)
  );

  // Full/empty come from count alone; pointers just wrap.
  always_comb begin
    push = in_st_q == IN_IDLE && in_req && count_q < DEPTH;
    pop = out_st_q == OUT_REQ && out_ack;
    in_st_d = push ? IN_ACK : (in_st_q == IN_ACK && !in_req) ? IN_IDLE : in_st_q;
    out_st_d = out_st_q;
    out_data_d = out_data_q;
    case (out_st_q)
      OUT_IDLE: if (count_q != '0) begin
        out_st_d = OUT_REQ;
        out_data_d = rd_data;
      end
      OUT_REQ: if (out_ack) out_st_d = OUT_WAIT;
      default: if (!out_ack) out_st_d = OUT_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + ADDR_BITS'(push);
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop);
    count_d = count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_st_q <= IN_IDLE;
      out_st_q <= OUT_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_data_q <= '0;
    end else begin
      in_st_q <= in_st_d;
      out_st_q <= out_st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ack = in_st_q == IN_ACK;
  assign out_req = out_st_q == OUT_REQ;
  assign out_data = out_data_q;
  assign count = count_q;

`ifdef CHANNEL_FIFO_DEBUG_EN
  logic [SIZE-1:0] prev_data_q;
  logic            prev_wait_q;
  task automatic print_prefix(input string name, input int id);
    $write("[%0t] %s %0d: ", $time, name, id);
  endtask
  always @(posedge clk) begin
    if (reset) begin
      if (push) begin
        print_prefix("Channel", ID);
        $display("push %h count %0d", in_data, count_d);
      end
      if (pop) begin
        print_prefix("Channel", ID);
        $display("pop %h count %0d", out_data_q, count_d);
      end
      if (prev_wait_q && in_req && !in_ack && in_data != prev_data_q) begin
        print_prefix("Channel", ID);
        $display("ERROR: in_data changed while in_req high and in_ack low");
      end
    end
    prev_wait_q <= reset && in_req && !in_ack;
    prev_data_q <= in_data;
  end
`else
  logic unused_id;
  assign unused_id = ID != 0;
`endif
endmodule

// File: tb/tb_channel_fifo.sv
// tb_channel_fifo: vector table, corner sequences and randomized traffic vs a queue model.
module tb_channel_fifo;
  logic       clk = 0, reset = 0, in_req = 0, out_ack = 0;
  logic [7:0] in_data = 0;
  logic       in_ack, out_req;
  logic [7:0] out_data, pd;
  logic [2:0] count;
  int         n_cmp = 0, n_err = 0;

  channel_fifo #(.SIZE(8), .ADDR_BITS(2), .ID(0)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: accepted flits queue up in order; occupancy = accepted - released.
  logic [7:0] sb[$];
  logic [7:0] cur;
  int         n_push, n_pop;
  logic       ia_p, or_p;
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      n_push = 0;
      n_pop = 0;
      ia_p = 0;
      or_p = 0;
    end else begin
      if (in_ack && !ia_p) begin
        sb.push_back(in_data);
        n_push++;
      end
      if (out_req && !or_p) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL order: out_req with no pending flit, got %h", out_data);
        end else begin
          chk("order", out_data, sb[0]);
          cur = sb.pop_front();
        end
      end else if (out_req) chk("out_data_stable", out_data, cur);
      if (!out_req && or_p) n_pop++;
      chk("count_model", count, n_push - n_pop);
      chk("count_max", count <= 4, 1);
      ia_p = in_ack;
      or_p = out_req;
    end
  end

  task automatic push(input logic [7:0] d, input int maxd);
    int k;
    repeat ($urandom_range(0, maxd)) @(negedge clk);
    in_data = d;
    in_req = 1;
    for (k = 0; k < 200 && !in_ack; k++) @(negedge clk);
    chk("push_wait_ack", in_ack, 1);
    in_req = 0;
    for (k = 0; k < 200 && in_ack; k++) @(negedge clk);
    chk("push_wait_release", in_ack, 0);
  endtask

  task automatic pop(input int maxd, output logic [7:0] d);
    int k;
    for (k = 0; k < 200 && !out_req; k++) @(negedge clk);
    chk("pop_wait_req", out_req, 1);
    d = out_data;
    repeat ($urandom_range(0, maxd)) @(negedge clk);
    out_ack = 1;
    for (k = 0; k < 200 && out_req; k++) @(negedge clk);
    chk("pop_wait_drop", out_req, 0);
    repeat ($urandom_range(0, maxd)) @(negedge clk);
    out_ack = 0;
  endtask

  typedef struct {
    logic       req;
    logic [7:0] d;
    logic       ack;
    logic       e_iack;
    logic       e_oreq;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
  } vec_t;
  vec_t tv[5];

  initial begin
    tv[0] = '{1, 8'hA5, 0, 1, 0, 8'h00, 3'd1};
    tv[1] = '{0, 8'hA5, 0, 0, 1, 8'hA5, 3'd1};
    tv[2] = '{0, 8'hA5, 1, 0, 0, 8'hA5, 3'd0};
    tv[3] = '{0, 8'hA5, 0, 0, 0, 8'hA5, 3'd0};
    tv[4] = '{0, 8'hA5, 0, 0, 0, 8'hA5, 3'd0};
    repeat (3) @(negedge clk);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      in_req = tv[i].req;
      in_data = tv[i].d;
      out_ack = tv[i].ack;
      @(negedge clk);
      chk($sformatf("v%0d_in_ack", i), in_ack, tv[i].e_iack);
      chk($sformatf("v%0d_out_req", i), out_req, tv[i].e_oreq);
      chk($sformatf("v%0d_out_data", i), out_data, tv[i].e_od);
      chk($sformatf("v%0d_count", i), count, tv[i].e_cnt);
    end
    for (int i = 1; i <= 4; i++) push(8'(i), 0);
    chk("fill_count", count, 4);
    in_data = 8'h05;
    in_req = 1;
    repeat (3) @(negedge clk);
    chk("full_no_ack", in_ack, 0);
    chk("full_count", count, 4);
    chk("full_head", out_data, 8'h01);
    out_ack = 1;
    @(negedge clk);
    chk("full_pop_out_req", out_req, 0);
    chk("full_pop_count", count, 3);
    chk("full_pop_in_ack", in_ack, 0);
    out_ack = 0;
    @(negedge clk);
    chk("full_accept", in_ack, 1);
    chk("refill_count", count, 4);
    in_req = 0;
    @(negedge clk);
    for (int i = 2; i <= 5; i++) begin
      pop(1, pd);
      chk("fill_order", pd, 8'(i));
    end
    chk("fill_drain_count", count, 0);
    fork
      for (int i = 0; i < 10; i++) push(8'h10 + 8'(i), 3);
      for (int j = 0; j < 10; j++) begin
        pop(3, pd);
        chk("wrap_order", pd, 8'h10 + 8'(j));
      end
    join
    chk("wrap_count", count, 0);
    push(8'hB1, 0);
    push(8'hB2, 0);
    chk("sim_pre_count", count, 2);
    chk("sim_head", out_data, 8'hB1);
    in_data = 8'hB3;
    in_req = 1;
    out_ack = 1;
    @(negedge clk);
    chk("sim_count", count, 2);
    chk("sim_in_ack", in_ack, 1);
    chk("sim_out_req", out_req, 0);
    in_req = 0;
    out_ack = 0;
    @(negedge clk);
    pop(0, pd);
    chk("sim_order1", pd, 8'hB2);
    pop(0, pd);
    chk("sim_order2", pd, 8'hB3);
    chk("sim_drain_count", count, 0);
    push(8'hC1, 0);
    in_data = 8'h3C;
    in_req = 1;
    @(negedge clk);
    chk("pre_rst_in_ack", in_ack, 1);
    chk("pre_rst_out_req", out_req, 1);
    #2 reset = 0;
    #1;
    chk("async_rst_in_ack", in_ack, 0);
    chk("async_rst_out_req", out_req, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_count", count, 0);
    @(negedge clk);
    #2 reset = 1;
    @(negedge clk);
    chk("post_rst_in_ack", in_ack, 1);
    chk("post_rst_count", count, 1);
    in_req = 0;
    @(negedge clk);
    pop(2, pd);
    chk("post_rst_data", pd, 8'h3C);
    chk("post_rst_count_end", count, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
